// File: rtl/pwm_capture_if.sv
// PWM capture bus: sampled input plus measurement results.
// Duty fields exist only when PWM_CAP_DUTY_EN is defined.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             pwm_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid_out;
  logic             overflow_out;
`ifdef PWM_CAP_DUTY_EN
  logic [7:0]       duty_out;
  logic             duty_valid_out;

  modport master (
    input  pwm_in,
    output period_out, high_out,
    output valid_out, overflow_out,
    output duty_out, duty_valid_out
  );
  modport slave (
    output pwm_in,
    input  period_out, high_out,
    input  valid_out, overflow_out,
    input  duty_out, duty_valid_out
  );
`else
  modport master (
    input  pwm_in,
    output period_out, high_out,
    output valid_out, overflow_out
  );
  modport slave (
    output pwm_in,
    input  period_out, high_out,
    input  valid_out, overflow_out
  );
`endif
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures period/high time of an async PWM input.
// PWM_CAP_DUTY_EN adds an 8-step restoring divider for duty_out.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  pwm_capture_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOW   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic                   rise_q;
  logic                   fall_q;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       h_tmp;
  state_t                 state;
  state_t                 state_nx;
  logic                   ld_h;
  logic                   ld_out;
  logic                   ovf;
  logic                   tmo;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // edges are registered once so the strobe lands SYNC_STAGES+1 after sampling
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync   <= '0;
      s_d    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], bus.pwm_in};
      s_d    <= s;
      rise_q <= rise;
      fall_q <= fall;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt <= '0;
    end else if (rise_q) begin
      cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tmo = (cnt == CNT_MAX) & ~rise_q & ~fall_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ld_h     = 1'b0;
    ld_out   = 1'b0;
    ovf      = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise_q) state_nx = ARMED;
      end
      ARMED: begin
        if (fall_q) begin
          ld_h     = 1'b1;
          state_nx = LOW;
        end else if (tmo) begin
          ovf      = 1'b1;
          state_nx = IDLE;
        end
      end
      LOW: begin
        if (rise_q) begin
          ld_out   = 1'b1;
          state_nx = ARMED;
        end else if (tmo) begin
          ovf      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      h_tmp            <= '0;
      bus.period_out   <= '0;
      bus.high_out     <= '0;
      bus.valid_out    <= 1'b0;
      bus.overflow_out <= 1'b0;
    end else begin
      bus.valid_out    <= ld_out;
      bus.overflow_out <= ovf;
      if (ld_h) h_tmp <= cnt;
      if (ld_out) begin
        bus.period_out <= cnt;
        bus.high_out   <= h_tmp;
      end
    end
  end

`ifdef PWM_CAP_DUTY_EN
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] dvs;
  logic [7:0]       quo;
  logic [2:0]       it;
  logic             busy;
  logic [CNT_W:0]   rem_sh;
  logic [CNT_W:0]   rem_nx;
  logic             q_bit;

  // high < period, so the remainder always fits CNT_W bits
  always_comb begin
    rem_sh = {rem, 1'b0};
    q_bit  = (rem_sh >= {1'b0, dvs});
    rem_nx = q_bit ? (rem_sh - {1'b0, dvs}) : rem_sh;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rem                <= '0;
      dvs                <= '0;
      quo                <= '0;
      it                 <= '0;
      busy               <= 1'b0;
      bus.duty_out       <= '0;
      bus.duty_valid_out <= 1'b0;
    end else begin
      bus.duty_valid_out <= 1'b0;
      if (ld_out) begin
        rem  <= h_tmp;
        dvs  <= cnt;
        quo  <= '0;
        it   <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        rem <= rem_nx[CNT_W-1:0];
        quo <= {quo[6:0], q_bit};
        it  <= it + 1'b1;
        if (it == 3'd7) begin
          busy               <= 1'b0;
          bus.duty_out       <= {quo[6:0], q_bit};
          bus.duty_valid_out <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
